// File: rtl/rgb_seq_monitor_if.sv
// Purpose : groups the observed colour lines, the error-clear control and the
//           monitor's status outputs into one bundle for rgb_seq_monitor.
// Ports   : red/green/blue/clear_err (into the monitor); press_seen, seq_done,
//           err_pulse, err_flag, err_code, seq_count (out of the monitor).
// Macro   : RGB_MON_ERRCNT_EN adds err_count to the bundle.
interface rgb_seq_monitor_if #(
  parameter int COUNT_W = 8
);
  logic               red;
  logic               green;
  logic               blue;
  logic               clear_err;
  logic               press_seen;
  logic               seq_done;
  logic               err_pulse;
  logic               err_flag;
  logic [1:0]         err_code;
  logic [COUNT_W-1:0] seq_count;
`ifdef RGB_MON_ERRCNT_EN
  logic [COUNT_W-1:0] err_count;
`endif

  // Monitor side: samples the colour lines, drives the status.
  modport slave (
`ifdef RGB_MON_ERRCNT_EN
    output err_count,
`endif
    input  red, green, blue, clear_err,
    output press_seen, seq_done, err_pulse, err_flag, err_code, seq_count
  );

  // Observer side: drives the colour lines, reads the status.
  modport master (
`ifdef RGB_MON_ERRCNT_EN
    input  err_count,
`endif
    output red, green, blue, clear_err,
    input  press_seen, seq_done, err_pulse, err_flag, err_code, seq_count
  );
endinterface

// File: rtl/rgb_seq_monitor.sv
// Purpose : checks the RGB sequencer outputs against BLANK->RED->GREEN->BLUE->BLANK
//           (one cycle per colour), reporting presses, completed sequences and
//           violations (MULTI over ORDER over STALL).
// Ports   : clk, reset (async, active-high); mon (slave modport) carries
//           red/green/blue/clear_err in and all status outputs back.
// Latency : inputs (including clear_err) are captured at edge N; the resulting
//           status is visible after edge N+1. All outputs registered, reset to 0.
// Macro   : RGB_MON_ERRCNT_EN adds a saturating err_count of err_pulse events.
module rgb_seq_monitor #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  rgb_seq_monitor_if.slave   mon
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_RED   = 3'd1,
    S_GREEN = 3'd2,
    S_BLUE  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [1:0] CODE_MULTI = 2'b01;
  localparam logic [1:0] CODE_ORDER = 2'b10;
  localparam logic [1:0] CODE_STALL = 2'b11;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_t             state, next_state;
  logic [2:0]         in_q;          // {red, green, blue} as captured
  logic               clr_q;
  logic               press_r, done_r, err_pulse_r, err_flag_r;
  logic [1:0]         err_code_r;
  logic [COUNT_W-1:0] seq_count_r;

  logic               is_none, is_r, is_g, is_b, is_multi;
  logic               err_hit, press_nxt, done_nxt;
  logic [1:0]         err_code_nxt;

  // Capture stage: gives every input, clear_err included, the same latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q  <= 3'b000;
      clr_q <= 1'b0;
    end else begin
      in_q  <= {mon.red, mon.green, mon.blue};
      clr_q <= mon.clear_err;
    end
  end

  assign is_none  = (in_q == 3'b000);
  assign is_r     = (in_q == 3'b100);
  assign is_g     = (in_q == 3'b010);
  assign is_b     = (in_q == 3'b001);
  assign is_multi = !is_none && !is_r && !is_g && !is_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    err_hit      = 1'b0;
    err_code_nxt = 2'b00;
    press_nxt    = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (is_r) begin
          next_state = S_RED;
          press_nxt  = 1'b1;
        end else if (is_multi) begin
          err_hit = 1'b1; err_code_nxt = CODE_MULTI;
        end else if (!is_none) begin
          err_hit = 1'b1; err_code_nxt = CODE_ORDER;
        end
      end
      S_RED: begin
        if (is_g)          next_state = S_GREEN;
        else if (is_multi) begin err_hit = 1'b1; err_code_nxt = CODE_MULTI; end
        else if (is_none)  begin err_hit = 1'b1; err_code_nxt = CODE_STALL; end
        else               begin err_hit = 1'b1; err_code_nxt = CODE_ORDER; end
      end
      S_GREEN: begin
        if (is_b)          next_state = S_BLUE;
        else if (is_multi) begin err_hit = 1'b1; err_code_nxt = CODE_MULTI; end
        else if (is_none)  begin err_hit = 1'b1; err_code_nxt = CODE_STALL; end
        else               begin err_hit = 1'b1; err_code_nxt = CODE_ORDER; end
      end
      S_BLUE: begin
        // A blank cycle must separate sequences; any colour here is out of order.
        if (is_none) begin
          next_state = IDLE;
          done_nxt   = 1'b1;
        end else if (is_multi) begin
          err_hit = 1'b1; err_code_nxt = CODE_MULTI;
        end else begin
          err_hit = 1'b1; err_code_nxt = CODE_ORDER;
        end
      end
      ERROR: begin
        // Only a blank recovers; nothing else is reported or starts a sequence.
        if (is_none) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (err_hit) next_state = ERROR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_r     <= 1'b0;
      done_r      <= 1'b0;
      err_pulse_r <= 1'b0;
      err_flag_r  <= 1'b0;
      err_code_r  <= 2'b00;
      seq_count_r <= '0;
    end else begin
      press_r     <= press_nxt;
      done_r      <= done_nxt;
      err_pulse_r <= err_hit;
      // A new error outranks a clear arriving in the same cycle.
      if (err_hit) begin
        err_flag_r <= 1'b1;
        err_code_r <= err_code_nxt;
      end else if (clr_q) begin
        err_flag_r <= 1'b0;
        err_code_r <= 2'b00;
      end
      if (done_nxt && (seq_count_r != CNT_MAX))
        seq_count_r <= seq_count_r + 1'b1;
    end
  end

  assign mon.press_seen = press_r;
  assign mon.seq_done   = done_r;
  assign mon.err_pulse  = err_pulse_r;
  assign mon.err_flag   = err_flag_r;
  assign mon.err_code   = err_code_r;
  assign mon.seq_count  = seq_count_r;

`ifdef RGB_MON_ERRCNT_EN
  logic [COUNT_W-1:0] err_count_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_count_r <= '0;
    else if (err_hit && (err_count_r != CNT_MAX))
      err_count_r <= err_count_r + 1'b1;
  end

  assign mon.err_count = err_count_r;
`endif

endmodule

// File: tb/tb_rgb_seq_monitor.sv
// Directed bench for rgb_seq_monitor: one COUNT_W=8 instance and one COUNT_W=2
// instance share the same stimulus. After each step() the outputs reflect the
// vector applied in the previous step (capture edge + registered update edge).
module tb_rgb_seq_monitor;

  logic       clk;
  logic       reset;
  logic [2:0] rgb;
  logic       clr;
  int         checks;
  int         errors;

  rgb_seq_monitor_if #(.COUNT_W(8)) bus8 ();
  rgb_seq_monitor_if #(.COUNT_W(2)) bus2 ();

  assign {bus8.red, bus8.green, bus8.blue} = rgb;
  assign {bus2.red, bus2.green, bus2.blue} = rgb;
  assign bus8.clear_err = clr;
  assign bus2.clear_err = clr;

  rgb_seq_monitor #(.COUNT_W(8)) dut8 (.clk(clk), .reset(reset), .mon(bus8));
  rgb_seq_monitor #(.COUNT_W(2)) dut2 (.clk(clk), .reset(reset), .mon(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [2:0] v, input logic c);
    rgb = v;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic ps, input logic sd,
                              input logic ep, input logic ef, input logic [1:0] ec);
    check({tag, ".press_seen"}, {31'd0, bus8.press_seen}, {31'd0, ps});
    check({tag, ".seq_done"},   {31'd0, bus8.seq_done},   {31'd0, sd});
    check({tag, ".err_pulse"},  {31'd0, bus8.err_pulse},  {31'd0, ep});
    check({tag, ".err_flag"},   {31'd0, bus8.err_flag},   {31'd0, ef});
    check({tag, ".err_code"},   {30'd0, bus8.err_code},   {30'd0, ec});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rgb    = 3'b000;
    clr    = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_status("reset", 0, 0, 0, 0, 2'b00);
    check("reset.seq_count", {24'd0, bus8.seq_count}, 32'd0);
    reset = 1'b0;

    // Idle blanks
    repeat (5) step(3'b000, 0);
    check_status("idle", 0, 0, 0, 0, 2'b00);
    check("idle.seq_count", {24'd0, bus8.seq_count}, 32'd0);

    // One legal sequence
    step(3'b100, 0);
    step(3'b010, 0);
    check("legal.press", {31'd0, bus8.press_seen}, 32'd1);
    step(3'b001, 0);
    check("legal.press_gone", {31'd0, bus8.press_seen}, 32'd0);
    step(3'b000, 0);
    check("legal.no_done_yet", {31'd0, bus8.seq_done}, 32'd0);
    step(3'b000, 0);
    check_status("legal.done", 0, 1, 0, 0, 2'b00);
    check("legal.seq_count", {24'd0, bus8.seq_count}, 32'd1);
    step(3'b000, 0);
    check("legal.done_gone", {31'd0, bus8.seq_done}, 32'd0);

    // STALL: red followed by blank
    step(3'b100, 0);
    step(3'b000, 0);
    step(3'b000, 0);
    check_status("stall", 0, 0, 1, 1, 2'b11);
    step(3'b000, 0);
    check_status("stall.hold", 0, 0, 0, 1, 2'b11);
    step(3'b000, 1);
    step(3'b000, 0);
    check_status("stall.cleared", 0, 0, 0, 0, 2'b00);

    // ORDER: red straight after blue; trailing red must not pulse press_seen
    step(3'b100, 0);
    step(3'b010, 0);
    step(3'b001, 0);
    step(3'b100, 0);
    step(3'b000, 0);
    check_status("order", 0, 0, 1, 1, 2'b10);
    check("order.seq_count", {24'd0, bus8.seq_count}, 32'd1);
    step(3'b000, 0);
    check("order.recover_press", {31'd0, bus8.press_seen}, 32'd0);

    // MULTI in IDLE with flag still set
    step(3'b110, 0);
    step(3'b000, 0);
    check_status("multi", 0, 0, 1, 1, 2'b01);
    step(3'b000, 0);

    // Clear, then clear coinciding with a new MULTI error: error wins
    step(3'b000, 1);
    step(3'b000, 0);
    check_status("clear2", 0, 0, 0, 0, 2'b00);
    step(3'b011, 1);
    step(3'b100, 0);
    check_status("clr_vs_err", 0, 0, 1, 1, 2'b01);
`ifdef RGB_MON_ERRCNT_EN
    check("errcnt", {24'd0, bus8.err_count}, 32'd4);
`endif
    // Red while in ERROR, then a blank: red not seen as a press, no new error
    step(3'b010, 0);
    check_status("err.red", 0, 0, 0, 1, 2'b01);
    step(3'b000, 0);
    check_status("err.green", 0, 0, 0, 1, 2'b01);
    step(3'b000, 0);
    step(3'b000, 0);

    // Reset, then back-to-back sequences; COUNT_W=2 saturates at 3
    reset = 1'b1;
    #1;
    check("rst.seq_count8", {24'd0, bus8.seq_count}, 32'd0);
    check("rst.err_flag", {31'd0, bus8.err_flag}, 32'd0);
    reset = 1'b0;
    step(3'b000, 0);
    step(3'b000, 0);
    for (int i = 0; i < 5; i++) begin
      step(3'b100, 0);
      if (i > 0) begin
        check($sformatf("b2b.done%0d", i), {31'd0, bus2.seq_done}, 32'd1);
        check($sformatf("b2b.cnt2_%0d", i), {30'd0, bus2.seq_count}, (i < 3) ? i : 3);
        check($sformatf("b2b.cnt8_%0d", i), {24'd0, bus8.seq_count}, i);
      end
      step(3'b010, 0);
      step(3'b001, 0);
      step(3'b000, 0);
    end
    step(3'b000, 0);
    check("b2b.done5", {31'd0, bus2.seq_done}, 32'd1);
    check("b2b.cnt2_5", {30'd0, bus2.seq_count}, 32'd3);
    check("b2b.cnt8_5", {24'd0, bus8.seq_count}, 32'd5);
    check("b2b.no_err", {31'd0, bus8.err_flag}, 32'd0);

    // Reset mid-sequence: nothing counted, nothing flagged
    step(3'b100, 0);
    step(3'b010, 0);
    reset = 1'b1;
    #1;
    check("midrst.seq_count", {24'd0, bus8.seq_count}, 32'd0);
    check("midrst.press", {31'd0, bus8.press_seen}, 32'd0);
    reset = 1'b0;
    step(3'b000, 0);
    step(3'b000, 0);
    step(3'b000, 0);
    check_status("midrst.after", 0, 0, 0, 0, 2'b00);
    check("midrst.cnt2", {30'd0, bus2.seq_count}, 32'd0);
`ifdef RGB_MON_ERRCNT_EN
    check("midrst.errcnt", {24'd0, bus8.err_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
